// File: rtl/gpr_pkg.sv
// Shared types and defaults for the general-purpose register file.
// Widths here are the defaults; instances may override them.
package gpr_pkg;

  localparam int GPR_DATA_W   = 8;
  localparam int GPR_NUM_REGS = 8;
  localparam int GPR_ADDR_W   = $clog2(GPR_NUM_REGS);

  typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;
  typedef logic [GPR_DATA_W-1:0] gpr_data_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending bits for the register file: claim/clear, busy lookup,
// unclaimed-write diagnostic and registered pending count.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int NUM_REGS = GPR_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              wr_unclaimed,
  output logic [ADDR_W:0]   pending_cnt
);

  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_nxt;
  logic                wr_ok;
  logic                cl_ok;

  function automatic logic [ADDR_W:0] popcnt(
    input logic [NUM_REGS-1:0] v
  );
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++)
      c = c + (ADDR_W+1)'(v[i]);
    return c;
  endfunction

  assign wr_ok = wr_en &&
                 !(ZERO_REG && wr_addr == '0);
  assign cl_ok = claim_en &&
                 !(ZERO_REG && claim_addr == '0);

  // Claim applied after clear: a same-cycle claim wins.
  always_comb begin
    pend_nxt = pend;
    if (wr_ok)
      pend_nxt[wr_addr] = 1'b0;
    if (cl_ok)
      pend_nxt[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend         <= '0;
      wr_unclaimed <= 1'b0;
      pending_cnt  <= '0;
    end else begin
      pend         <= pend_nxt;
      wr_unclaimed <= wr_ok && !pend[wr_addr];
      pending_cnt  <= popcnt(pend_nxt);
    end
  end

  assign busy_a = pend[rd_addr_a] &&
                  !(wr_ok && wr_addr == rd_addr_a);
  assign busy_b = pend[rd_addr_b] &&
                  !(wr_ok && wr_addr == rd_addr_b);

endmodule

// File: rtl/gpr_file_sb.sv
// Register file with two bypassed read ports, one write port
// and a per-register pending scoreboard.
module gpr_file_sb
  import gpr_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int NUM_REGS = GPR_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              busy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_b,
  output logic              wr_unclaimed,
  output logic [ADDR_W:0]   pending_cnt
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;

  assign wr_ok = wr_en &&
                 !(ZERO_REG && wr_addr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (wr_ok && wr_addr == rd_addr_a)
      rd_data_a = wr_data;
    else if (ZERO_REG && rd_addr_a == '0)
      rd_data_a = '0;
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (wr_ok && wr_addr == rd_addr_b)
      rd_data_b = wr_data;
    else if (ZERO_REG && rd_addr_b == '0)
      rd_data_b = '0;
  end

  gpr_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .claim_en     (claim_en),
    .claim_addr   (claim_addr),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .busy_a       (busy_a),
    .busy_b       (busy_b),
    .wr_unclaimed (wr_unclaimed),
    .pending_cnt  (pending_cnt)
  );

endmodule

// File: tb/tb_gpr_file_sb.sv
// Random and directed bench for gpr_file_sb, one instance with
// and one without the hardwired zero register, against a model.
module tb_gpr_file_sb;
  import gpr_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      wr_en = 1'b0;
  gpr_addr_t wr_addr = '0;
  gpr_data_t wr_data = '0;
  logic      claim_en = 1'b0;
  gpr_addr_t claim_addr = '0;
  gpr_addr_t rd_addr_a = '0;
  gpr_addr_t rd_addr_b = '0;

  gpr_data_t rda [2];
  gpr_data_t rdb [2];
  logic      bsa [2];
  logic      bsb [2];
  logic      unc [2];
  logic [GPR_ADDR_W:0] cnt [2];

  int checks = 0;
  int failures = 0;

  int m_mem  [2][8];
  bit m_pend [2][8];
  bit m_unc  [2];

  always #5 clk = ~clk;

  gpr_file_sb #(.ZERO_REG(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda[0]), .busy_a(bsa[0]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb[0]), .busy_b(bsb[0]),
    .wr_unclaimed(unc[0]), .pending_cnt(cnt[0])
  );

  gpr_file_sb #(.ZERO_REG(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda[1]), .busy_a(bsa[1]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb[1]), .busy_b(bsb[1]),
    .wr_unclaimed(unc[1]), .pending_cnt(cnt[1])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit writable(input int z, input int a);
    return !(z == 1 && a == 0);
  endfunction

  function automatic int exp_data(input int z, input int a);
    if (wr_en && writable(z, int'(wr_addr)) && int'(wr_addr) == a)
      return int'(wr_data);
    if (!writable(z, a)) return 0;
    return m_mem[z][a];
  endfunction

  function automatic bit exp_busy(input int z, input int a);
    if (wr_en && writable(z, int'(wr_addr)) && int'(wr_addr) == a)
      return 1'b0;
    return m_pend[z][a];
  endfunction

  function automatic int exp_cnt(input int z);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_pend[z][i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      m_unc[z] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_mem[z][i] = 0;
        m_pend[z][i] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    for (int z = 0; z < 2; z++) begin
      m_unc[z] = 1'b0;
      if (wr_en && writable(z, int'(wr_addr))) begin
        m_unc[z] = !m_pend[z][wr_addr];
        m_mem[z][wr_addr] = int'(wr_data);
        m_pend[z][wr_addr] = 1'b0;
      end
      if (claim_en && writable(z, int'(claim_addr)))
        m_pend[z][claim_addr] = 1'b1;
    end
  endtask

  task automatic check_reads(input string tag);
    for (int z = 0; z < 2; z++) begin
      check($sformatf("%s z%0d rd_a", tag, z), 32'(rda[z]),
            32'(exp_data(z, int'(rd_addr_a))));
      check($sformatf("%s z%0d busy_a", tag, z), 32'(bsa[z]),
            32'(exp_busy(z, int'(rd_addr_a))));
      check($sformatf("%s z%0d rd_b", tag, z), 32'(rdb[z]),
            32'(exp_data(z, int'(rd_addr_b))));
      check($sformatf("%s z%0d busy_b", tag, z), 32'(bsb[z]),
            32'(exp_busy(z, int'(rd_addr_b))));
    end
  endtask

  task automatic check_regd(input string tag);
    for (int z = 0; z < 2; z++) begin
      check($sformatf("%s z%0d unclaimed", tag, z), 32'(unc[z]),
            32'(m_unc[z]));
      check($sformatf("%s z%0d cnt", tag, z), 32'(cnt[z]),
            32'(exp_cnt(z)));
    end
  endtask

  // Called just after a rising edge; returns just after the next.
  task automatic step(input string tag,
                      input bit we, input int wa, input int wd,
                      input bit ce, input int ca,
                      input int ra, input int rb);
    wr_en = we;
    wr_addr = gpr_addr_t'(wa);
    wr_data = gpr_data_t'(wd);
    claim_en = ce;
    claim_addr = gpr_addr_t'(ca);
    rd_addr_a = gpr_addr_t'(ra);
    rd_addr_b = gpr_addr_t'(rb);
    #3;
    check_reads(tag);
    @(posedge clk);
    model_edge();
    #1;
    check_regd(tag);
  endtask

  initial begin
    model_reset();
    #2;
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = gpr_addr_t'(a);
      rd_addr_b = gpr_addr_t'(7 - a);
      #1;
      check_reads("reset");
    end
    check_regd("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("byp_r3", 1, 3, 8'hA5, 0, 0, 3, 0);
    step("hold_r3", 0, 0, 0, 0, 0, 3, 3);
    check("r3 value", 32'(rda[0]), 32'h0000_00A5);
    step("claim_r5", 0, 0, 0, 1, 5, 0, 5);
    step("busy_r5", 0, 0, 0, 0, 0, 1, 5);
    check("r5 busy", 32'(bsb[0]), 32'd1);
    step("wr_r5", 1, 5, 8'h3C, 0, 0, 0, 5);
    step("after_r5", 0, 0, 0, 0, 0, 5, 5);
    step("clwr_r2", 1, 2, 8'h11, 1, 2, 2, 4);
    step("read_r2", 0, 0, 0, 0, 0, 2, 2);
    step("wr_r6", 1, 6, 8'h77, 0, 0, 6, 1);
    step("after_r6", 0, 0, 0, 0, 0, 6, 6);
    step("wr_r0", 1, 0, 8'hFF, 1, 0, 0, 0);
    step("read_r0", 0, 0, 0, 0, 0, 0, 0);
    step("diff_addr", 1, 4, 8'h42, 1, 7, 4, 7);
    step("diff_rd", 0, 0, 0, 0, 0, 4, 7);

    for (int n = 0; n < 400; n++) begin
      int wa = int'($urandom_range(0, 7));
      int ra = ($urandom_range(0, 3) == 0) ? wa :
               int'($urandom_range(0, 7));
      step("rand", 1'($urandom), wa, int'($urandom_range(0, 255)),
           1'($urandom), int'($urandom_range(0, 7)),
           ra, int'($urandom_range(0, 7)));
    end

    step("pre_rst_a", 0, 0, 0, 1, 1, 0, 0);
    step("pre_rst_b", 1, 3, 8'h5A, 1, 3, 0, 0);
    step("pre_rst_c", 0, 0, 0, 1, 6, 0, 0);
    wr_en = 1'b0;
    claim_en = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_regd("midrst");
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = gpr_addr_t'(a);
      rd_addr_b = gpr_addr_t'(a);
      #1;
      check_reads("midrst");
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst", 1, 1, 8'h99, 0, 0, 1, 3);
    step("post_rd", 0, 0, 0, 0, 0, 1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
Parametrised general-purpose register file for the next-generation datapath. It has two combinational read ports with write-to-read bypass and one synchronous write port. A per-register pending (scoreboard) bit lets the decode stage claim a destination register and stall on read-after-write hazards until writeback clears the claim. It sits between decode (claim, read) and writeback (write) and replaces the fixed 8x8 register bank.

Parameters:
DATA_W, 8, width of each register in bits.
NUM_REGS, 8, number of registers; must be a power of two and at least 2.
ADDR_W, $clog2(NUM_REGS), register address width; derived, do not override.
ZERO_REG, 0, when 1: register 0 always reads 0, ignores writes, and is never pending.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
wr_en  in  1  write strobe from writeback.
wr_addr  in  ADDR_W  write destination.
wr_data  in  DATA_W  write data.
claim_en  in  1  decode claims a destination register.
claim_addr  in  ADDR_W  register to mark pending.
rd_addr_a  in  ADDR_W  read port A address.
rd_data_a  out  DATA_W  read port A data.
busy_a  out  1  register at rd_addr_a is pending.
rd_addr_b  in  ADDR_W  read port B address.
rd_data_b  out  DATA_W  read port B data.
busy_b  out  1  register at rd_addr_b is pending.
wr_unclaimed  out  1  registered pulse: the previous cycle wrote a register that was not pending.
pending_cnt  out  ADDR_W+1  number of pending registers.

Behaviour:
- Reset: clk and rst_n as above; reset is asynchronous and active-low. While rst_n=0, all registers are 0, all pending bits are 0, wr_unclaimed=0 and pending_cnt=0. With all state cleared, rd_data_a/b=0 and busy_a/b=0.
- Write: on a rising edge with wr_en=1, reg[wr_addr] is updated to wr_data and pending[wr_addr] is cleared.
- Claim: on a rising edge with claim_en=1, pending[claim_addr] is set.
- Claim and write to the same address in the same cycle: data is written and pending stays set, because the claim is newer than the write.
- Claim and write to different addresses in the same cycle: both take effect independently.
- Read ports are combinational, zero latency. Bypass rule: if wr_en=1, wr_addr==rd_addr_x and the address is writable, then rd_data_x=wr_data and busy_x=0. Otherwise rd_data_x=reg[rd_addr_x] and busy_x=pending[rd_addr_x].
- The bypass also applies while claim_en hits the same address. busy reflects the state before the clock edge plus the write-port bypass; a same-cycle claim does not raise busy.
- Both read ports may address the same register; they must return identical values.
- ZERO_REG=1:
  - Writes to address 0 are dropped, including bypass; reads of address 0 return 0.
  - Claims of address 0 are ignored; busy for address 0 is always 0.
  - A write to address 0 does not raise wr_unclaimed.
- wr_unclaimed is registered. It is 1 in the cycle after a write to a writable register whose pending bit was 0 before that edge. This is a diagnostic only and does not block the write.
- pending_cnt is registered. It equals the population count of the pending bits after each edge and is exact for every claim/write combination (+1, -1, 0, unchanged).
- Reset asserted mid-operation clears everything immediately; nothing is preserved.
- Out-of-range addresses cannot occur because NUM_REGS is a power of two.

Decomposition:
- Shared package gpr_pkg:
  - default DATA_W and NUM_REGS constants;
  - a typedef for the register address;
  - a typedef for the data word.
- One natural sub-module, gpr_scoreboard, which holds the pending bits, busy lookup, wr_unclaimed and pending_cnt.
- The data array and bypass muxes stay in the top module.

Test Plan:
- Reset then read all addresses: rd_data_a/b=0, busy=0, pending_cnt=0.
- Write 0xA5 to r3 and read r3 on port A in the same cycle: rd_data_a=0xA5 via bypass. The next cycle, with no write, still returns 0xA5.
- Claim r5: busy_b=1 for rd_addr_b=5 and pending_cnt=1. Then write 0x3C to r5: in that cycle rd_data_b=0x3C and busy_b=0; afterwards pending_cnt=0 and wr_unclaimed=0.
- In one cycle, claim r2 and write 0x11 to r2: afterwards r2 reads 0x11, busy=1, pending_cnt=1.
- Write 0x77 to the never-claimed r6: wr_unclaimed=1 for exactly one cycle.
- With ZERO_REG=1, write 0xFF to r0 and claim r0: r0 reads 0, busy=0, pending_cnt=0.
- Drop rst_n mid-sequence with 3 registers pending: pending_cnt=0 and all registers read 0 immediately, without waiting for a clock edge.
